// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 encoding constants: instruction format codes,
//               base opcodes, the canonical NOP and the buffered word type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Format selector carried on in_fmt; codes 6 and 7 are illegal
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Base opcodes of the RV32I major groups
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'd0, 5'd0, 3'd0, 5'd0, OPC_OP_IMM};

  // Output buffer depth (occupancy fits in two bits)
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  // One buffered entry: encoded word plus its error flag
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Purely combinational RV32 field packer. Builds the 32-bit word
//               for the selected format and flags immediates that do not fit
//               (or are misaligned). Out-of-range immediates are still packed
//               in truncated form; illegal formats produce a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  // A signed value fits in N bits when bits [31:N-1] are all copies of the sign
  logic w_fits12;
  logic w_fits13;
  logic w_fits21;

  assign w_fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign w_fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign w_fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Format-driven packing and range/alignment checking
  always_comb begin
    instr_o = '0;
    err_o   = 1'b0;
    case (fmt_i)
      FMT_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o   = ~w_fits12;
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o   = ~w_fits12;
      end
      FMT_B: begin
        // 13-bit signed range with an even offset gives [-4096, 4094]
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        err_o   = ~w_fits13 | imm_i[0];
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        err_o   = |imm_i[11:0];
      end
      FMT_J: begin
        // 21-bit signed range with an even offset gives [-1048576, 1048574]
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o   = ~w_fits21 | imm_i[0];
      end
      default: begin
        instr_o = NOP_INSTR;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : RV32 instruction encoder with valid/ready handshakes. Each
//               accepted request is packed, pushed into a 2-entry FIFO with
//               its error flag, and a saturating 8-bit error counter tracks
//               accepted requests that were flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  logic [31:0] w_instr;
  logic        w_err;
  logic        w_push;
  logic        w_pop;

  enc_word_t   mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q,  count_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  instr_pack u_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .instr_o  (w_instr),
    .err_o    (w_err)
  );

  // Handshake flags depend only on registered occupancy (no out_ready -> in_ready path)
  assign in_ready  = (count_q < FIFO_DEPTH);
  assign out_valid = (count_q != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Head of FIFO is presented only while valid, zero otherwise
  assign out_instr = out_valid ? mem_q[rd_ptr_q].instr : 32'd0;
  assign out_err   = out_valid ? mem_q[rd_ptr_q].err   : 1'b0;
  assign err_count = err_cnt_q;

  // Next-state for pointers, occupancy and saturating error counter
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (w_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (w_push && w_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Control state register; reset flushes everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // FIFO storage; written at the write pointer on every accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= '{instr: w_instr, err: w_err};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder with directed vectors
//               and randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int checks;
  int errors;

  logic [32:0] exp_q [$];
  int          exp_errs;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Reference encoder: range rules as plain signed arithmetic, returns {instr, err}
  function automatic logic [32:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] imm);
    longint v;
    logic [31:0] w;
    logic e;
    v = longint'($signed(imm));
    w = 32'h0000_0013;
    e = 1'b1;
    case (f)
      3'd0: begin w = {f7, rs2, rs1, f3, rd, op}; e = 1'b0; end
      3'd1: begin w = {imm[11:0], rs1, f3, rd, op}; e = (v < -2048) || (v > 2047); end
      3'd2: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; e = (v < -2048) || (v > 2047); end
      3'd3: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin w = {imm[31:12], rd, op}; e = (v % 4096 != 0); end
      3'd5: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
    return {w, e};
  endfunction

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic randomize_fields();
    int bnd [15] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, 4096, -4097,
                     -1048576, 1048574, 1048576, -1048578, 3, 0};
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = 32'(int'($urandom_range(0, 10000)) - 5000);
      1: imm = $urandom;
      2: imm = 32'(bnd[$urandom_range(0, 14)]);
      default: imm = $urandom & 32'hFFFF_F000;
    endcase
    set_fields(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), imm);
  endtask

  function automatic logic [32:0] cur_ref();
    return ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
  endfunction

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_errs = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %0b exp 0", out_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_itype();
    out_ready = 1'b1;
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL itype_valid got %0b exp 1", out_valid); end
    checks++; if ({out_instr, out_err} !== {32'h0050_0093, 1'b0}) begin errors++; $display("FAIL itype_word got %h/%0b exp 00500093/0", out_instr, out_err); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL itype_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    set_fields(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if ({out_instr, out_err} !== {32'hFE20_8CE3, 1'b0}) begin errors++; $display("FAIL branch_neg8 got %h/%0b exp FE208CE3/0", out_instr, out_err); end
    in_imm = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_instr, out_err} !== {32'h0020_8163, 1'b1}) begin errors++; $display("FAIL branch_odd got %h/%0b exp 00208163/1", out_instr, out_err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL branch_err_count got %0d exp 1", err_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_jump_illegal();
    out_ready = 1'b1;
    set_fields(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if ({out_instr, out_err} !== {32'h0010_00EF, 1'b0}) begin errors++; $display("FAIL jal_word got %h/%0b exp 001000EF/0", out_instr, out_err); end
    in_fmt = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_instr, out_err} !== {32'h0000_0013, 1'b1}) begin errors++; $display("FAIL illegal_fmt got %h/%0b exp 00000013/1", out_instr, out_err); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL illegal_err_count got %0d exp 2", err_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [32:0] acc_q [$];
    logic [32:0] e;
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (5) begin
      randomize_fields();
      @(negedge clk);
      if (in_ready) acc_q.push_back(cur_ref());
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", acc_q.size()); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || k >= acc_q.size() || {out_instr, out_err} !== acc_q[k]) begin
        errors++; $display("FAIL bp_order_%0d got %0b %h/%0b", k, out_valid, out_instr, out_err);
      end
      if (k == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %0b exp 1", in_ready); end
      end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", out_valid); end
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      randomize_fields();
      e = cur_ref();
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || {out_instr, out_err} !== e) begin
        errors++; $display("FAIL stream_%0d got v%0b r%0b %h/%0b exp %h/%0b", k, out_valid, in_ready, out_instr, out_err, e[32:1], e[0]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_fields(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL mid_pre_count got %0d exp 3", err_count); end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_full got v%0b r%0b exp v1 r0", out_valid, in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL mid_async got v%0b cnt %0d exp v0 cnt 0", out_valid, err_count); end
    checks++; if (out_instr !== 32'd0 || out_err !== 1'b0) begin errors++; $display("FAIL mid_async_data got %h/%0b exp 0/0", out_instr, out_err); end
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got r%0b v%0b exp r1 v0", in_ready, out_valid); end
  endtask

  task automatic test_saturation();
    int acc;
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    acc = 0;
    repeat (300) begin
      if ($urandom_range(0, 1) == 0) set_fields(3'($urandom_range(6, 7)), 7'($urandom), 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, $urandom);
      else set_fields(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5000);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (acc == 254) begin
        checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", err_count); end
      end
    end
    in_valid = 1'b0;
    checks++; if (acc != 300) begin errors++; $display("FAIL sat_accepted got %0d exp 300", acc); end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", err_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [32:0] e;
    logic push;
    logic pop;
    apply_reset();
    repeat (500) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      randomize_fields();
      @(negedge clk);
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid got %0b exp %0b", out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if ({out_instr, out_err} !== exp_q[0]) begin errors++; $display("FAIL rand_head got %h/%0b exp %h/%0b", out_instr, out_err, exp_q[0][32:1], exp_q[0][0]); end
      end
      checks++; if (in_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL rand_ready got %0b exp %0b", in_ready, exp_q.size() < 2); end
      checks++; if (int'(err_count) != exp_errs) begin errors++; $display("FAIL rand_err_count got %0d exp %0d", err_count, exp_errs); end
      push = in_valid && (exp_q.size() < 2);
      pop  = out_ready && (exp_q.size() != 0);
      e    = cur_ref();
      @(posedge clk); #1;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(e);
        if (e[0] && exp_errs < 255) exp_errs++;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_errs = 0;
    test_reset();
    test_itype();
    test_branch();
    test_jump_illegal();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
